// File: rtl/sub_add_pkg.sv
// sub_add_pkg
//   Shared definitions for the adder/subtractor core and its users.
//   OP_ADD / OP_SUB are the encodings of the cin op-select bit.
//   flags_t bundles the three status flags produced next to the result.
package sub_add_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } flags_t;

  // Zero detect on an arbitrary-width vector, capped at 64 bits.
  function automatic logic is_zero(input logic [63:0] val);
    return ~|val;
  endfunction

endpackage

// File: rtl/sub_add_full_adder.sv
// full_adder
//   One bit of the ripple chain.
//   Ports:
//     a, b  in   operand bits
//     ci    in   carry in from the lower stage
//     s     out  sum bit
//     co    out  carry out to the upper stage
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/sub_add.sv
// sub_add
//   Registered two's-complement adder/subtractor with carry, overflow and
//   zero flags. cin = 0 adds, cin = 1 subtracts (a + ~b + 1). Results and
//   flags appear one clock after in_valid.
//   Ports:
//     clk        in   clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   capture a/b/cin this cycle
//     a, b       in   WIDTH-bit operands
//     cin        in   op select / carry-in of the chain
//     out_valid  out  result and flags were updated this cycle
//     result     out  a+b or a-b modulo 2^WIDTH
//     carry      out  raw carry out of the MSB stage (subtract: 1 = no borrow)
//     overflow   out  signed overflow
//     zero       out  result == 0
module sub_add
  import sub_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c;
  flags_t           flags_nxt;
  flags_t           flags_q;

  // Subtract inverts b and injects the +1 through the chain carry-in.
  assign bb   = b ^ {WIDTH{cin}};
  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a  (a[i]),
      .b  (bb[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  always_comb begin
    flags_nxt.carry    = c[WIDTH];
    // Overflow when both effective operands share a sign the result lacks.
    flags_nxt.overflow = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    flags_nxt.zero     = ~|sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags_q   <= '{carry: 1'b0, overflow: 1'b0, zero: 1'b1};
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result  <= sum;
        flags_q <= flags_nxt;
      end
    end
  end

  assign carry    = flags_q.carry;
  assign overflow = flags_q.overflow;
  assign zero     = flags_q.zero;

endmodule

// File: tb/tb_sub_add.sv
module tb_sub_add;
  import sub_add_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic [W-1:0] result;
  logic         carry, overflow, zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sub_add #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero)
  );

  typedef struct {
    logic         op;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] res;
    logic         c;
    logic         ov;
    logic         z;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {out_valid, result, carry, overflow, zero}
  function automatic logic [31:0] pack_out();
    return {24'd0, out_valid, result, carry, overflow, zero};
  endfunction

  function automatic logic [31:0] pack_exp(input logic v, input logic [W-1:0] r,
                                           input logic c, input logic o, input logic z);
    return {24'd0, v, r, c, o, z};
  endfunction

  // Drive one operation at a negedge, then sample at the following negedge.
  task automatic apply(input logic op, input logic [W-1:0] va, input logic [W-1:0] vb);
    @(negedge clk);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    cin      = op;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int sa, sb, ss, us;
    logic [W-1:0] er;
    logic ec, eo;

    vecs[0] = '{OP_ADD, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{OP_ADD, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{OP_SUB, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{OP_SUB, 4'h8, 4'h1, 4'h7, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{OP_SUB, 4'h5, 4'h5, 4'h0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{OP_ADD, 4'h3, 4'h4, 4'h7, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{OP_ADD, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{OP_SUB, 4'h0, 4'h1, 4'hF, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{OP_SUB, 4'h7, 4'hF, 4'h8, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{OP_ADD, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    chk("reset_state", pack_out(), pack_exp(1'b0, 4'h0, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].op, vecs[i].va, vecs[i].vb);
      chk($sformatf("vec%0d", i), pack_out(),
          pack_exp(1'b1, vecs[i].res, vecs[i].c, vecs[i].ov, vecs[i].z));
    end

    // Hold: with in_valid low, values stay and out_valid drops.
    @(negedge clk);
    chk("hold", pack_out(), pack_exp(1'b0, 4'h0, 1'b0, 1'b0, 1'b1));

    // Back-to-back: two results on consecutive cycles.
    @(negedge clk);
    in_valid = 1'b1; a = 4'h2; b = 4'h3; cin = OP_ADD;
    @(negedge clk);
    chk("b2b_first", pack_out(), pack_exp(1'b1, 4'h5, 1'b0, 1'b0, 1'b0));
    a = 4'h9; b = 4'h2; cin = OP_SUB;
    @(negedge clk);
    chk("b2b_second", pack_out(), pack_exp(1'b1, 4'h7, 1'b1, 1'b1, 1'b0));

    // Asynchronous reset mid-stream with in_valid still high.
    a = 4'h6; b = 4'h6; cin = OP_ADD;
    @(posedge clk);
    #2;
    chk("pre_reset", pack_out(), pack_exp(1'b1, 4'hC, 1'b0, 1'b1, 1'b0));
    rst_n = 1'b0;
    #1;
    chk("async_reset", pack_out(), pack_exp(1'b0, 4'h0, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_capture", pack_out(), pack_exp(1'b1, 4'hC, 1'b0, 1'b1, 1'b0));
    in_valid = 1'b0;

    // Exhaustive sweep against an integer reference.
    for (int op = 0; op < 2; op++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          sa = (ia > 7) ? ia - 16 : ia;
          sb = (ib > 7) ? ib - 16 : ib;
          if (op == 1) begin
            us = ia - ib;
            ss = sa - sb;
            ec = (ia >= ib);
          end else begin
            us = ia + ib;
            ss = sa + sb;
            ec = (us > 15);
          end
          er = W'(us & 15);
          eo = (ss > 7) || (ss < -8);
          apply(op[0], W'(ia), W'(ib));
          chk($sformatf("sweep op%0d a%0h b%0h", op, ia, ib), pack_out(),
              pack_exp(1'b1, er, ec, eo, (er == 0)));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
